aes_key_schedule_multi: RTL and testbench
=========================================

# aes_key_schedule_multi

Parametrised AES key-schedule engine supporting AES-128, AES-192 and AES-256, selected per run. It expands a cipher key one 32-bit word per clock into an internal round-key store and exposes per-round valid status. A read port lets the cipher datapath consume early round keys while later ones are still being generated. It supersedes the fixed AES-128, row-per-cycle key expansion in the crypto accelerator.

## Interface
- MAX_KEY_BITS, 256, largest key length supported (128, 192 or 256). Sets the store depth to 4*(MAX_NR+1) words, where MAX_NR = 10/12/14.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  begin an expansion; sampled only when busy_o=0
- key_len_i  in  2  key length: 0=128, 1=192, 2=256, 3=reserved
- key_i  in  256  cipher key, left-aligned. key_i[255:224] is w[0]; unused low bits are ignored.
- rk_idx_i  in  4  round index to read
- rk_o  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r=rk_idx_i; combinational read
- rk_valid_o  out  1  the round addressed by rk_idx_i is fully written and r<=Nr
- busy_o  out  1  expansion in progress
- done_o  out  1  one-cycle pulse when the last word is written
- err_o  out  1  one-cycle pulse when a start request is rejected
- nr_o  out  4  Nr of the last accepted run (10/12/14)

## Operation
- Derived values: Nk = 4/6/8, Nr = 10/12/14, total words T = 4*(Nr+1) = 44/52/60.
- States are IDLE, GEN and DONE. DONE differs from IDLE only in that the store contents and valid status are retained.
- Start acceptance:
  - start_i is accepted in IDLE or DONE.
  - A request with key_len_i=3, or with a key length above MAX_KEY_BITS, is rejected: err_o pulses, the state is unchanged and the store is untouched.
- On acceptance edge E0:
  - w[0..Nk-1] are loaded from key_i.
  - wcnt := Nk, i := Nk, j := 0 (j = i mod Nk).
  - rcon := 8'h01.
  - nr_o is updated and the state moves to GEN.
- GEN, one word per edge: temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon := xtime(rcon), i.e. {rcon[6:0],0} ^ (rcon[7] ? 8'h1b : 0).
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - w[i] := w[i-Nk] ^ temp; i, wcnt increment; j wraps at Nk-1 -> 0.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. At most 10 values are consumed (AES-128 uses all 10; AES-256 uses 7).
- SubWord uses a single 4-byte S-box lookup per cycle.
- GEN -> DONE on the edge that writes w[T-1]. On that same edge busy_o goes 0 and done_o goes 1.
- rk_valid_o = (rk_idx_i <= Nr) && (wcnt >= 4*rk_idx_i + 4). This value is 0 in IDLE after reset.
- rk_o for an unwritten or out-of-range index is don't-care, but it must not be X-propagating. The store resets to zero.
- start_i during GEN is ignored; no queuing and no err_o.
- A restart from DONE reloads the store and resets wcnt on E0. Validity of the old rounds drops in the cycle after E0, except for round 0 and any other rounds covered by the new Nk-word load.

## Timing
- Reset (async assert, any state): state=IDLE, busy_o=0, done_o=0, err_o=0, nr_o=0, wcnt=0, rcon=01, store=0, rk_valid_o=0.
- After E0, busy_o=1 in the following cycle, and round 0 is valid from that cycle.
- Round r becomes valid in the cycle after the edge writing w[4r+3]. That is 4r+4-Nk edges after E0, with a minimum of immediately after E0.
- Generation takes T-Nk edges after E0: 40 for AES-128, 46 for AES-192, 52 for AES-256. done_o is high in the cycle after edge E(T-Nk), for exactly one cycle.
- A start_i held high in DONE immediately restarts. The minimum start-to-start interval is T-Nk+1 cycles.
- Read path is combinational: rk_o and rk_valid_o follow rk_idx_i in the same cycle.
- Reset deasserted mid-run leaves no residual state. The next start behaves as a first run.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done_o pulses 40 cycles after E0; nr_o=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> round 12 = e98ba06f448c773c8ecc720401002202; done_o pulses after 46 cycles.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> round 14 = fe4890d1e6188d0b046df344706c631e; done_o pulses after 52 cycles; the j==4 SubWord path is exercised.
- Progressive validity during an AES-128 run: with rk_idx_i=3, rk_valid_o rises exactly 12 edges after E0; with rk_idx_i=11, rk_valid_o stays 0 throughout.
- Rejection and ignored starts:
  - key_len_i=3 -> err_o pulses, busy_o stays 0.
  - With MAX_KEY_BITS=128, key_len_i=2 -> err_o pulses, busy_o stays 0.
  - start_i during GEN -> ignored, and the round keys are unchanged.
- Reset and back-to-back runs:
  - Assert rst_ni at word 20 of an AES-256 run -> all outputs return to reset values asynchronously; the next AES-128 run produces the correct vectors.
  - Back-to-back restart from DONE with a different length gives correct results.

Source files
------------

// File: rtl/aes_key_schedule_multi.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_multi
//
// AES key-schedule engine for AES-128/192/256, with the key length chosen
// per run. The cipher key is expanded one 32-bit word per clock into an
// internal round-key store. Early round keys can be read while later words
// are still being generated.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   start_i      begin an expansion (looked at only in IDLE / DONE)
//   key_len_i    0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
//   key_i        cipher key, left-aligned (key_i[255:224] is w[0])
//   rk_idx_i     round index for the read port
//   rk_o         {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = rk_idx_i
//   rk_valid_o   round rk_idx_i is fully written and r <= Nr
//   busy_o       expansion in progress
//   done_o       one-cycle pulse after the last word is written
//   err_o        one-cycle pulse after a start request is rejected
//   nr_o         Nr of the last accepted run (10/12/14)
//   dbg_state_o  current FSM state (0=IDLE, 1=GEN, 2=DONE)
//
// Handshake: start_i is a level request. It is accepted on a rising edge
// where the engine is in IDLE or DONE and start_i=1. Accepted requests show
// up as busy_o=1 in the next cycle. Rejected requests show up as err_o=1 in
// the next cycle. While busy_o=1, start_i is ignored.
// ---------------------------------------------------------------------------
module aes_key_schedule_multi #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [1:0]   key_len_i,
    input  logic [255:0] key_i,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o,
    output logic         rk_valid_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [3:0]   nr_o,
    output logic [1:0]   dbg_state_o
);

    localparam int MAX_NR = (MAX_KEY_BITS >= 256) ? 14 :
                            (MAX_KEY_BITS >= 192) ? 12 : 10;
    localparam int DEPTH  = 4 * (MAX_NR + 1);
    localparam logic [6:0] DEPTH_W = 7'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic for the S-box (reduction polynomial 0x11b)
    // ------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^
               {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0] w_q [DEPTH];
    logic [5:0]  wcnt_q;     // words written so far; also the next write index
    logic [2:0]  j_q;        // wcnt_q mod Nk
    logic [7:0]  rcon_q;
    logic [3:0]  nk_q;
    logic [3:0]  nr_q;
    logic [5:0]  total_q;    // 4*(Nr+1)
    logic        done_q;
    logic        err_q;

    // ------------------------------------------------------------------
    // Key-length decode of the incoming request
    // ------------------------------------------------------------------
    logic [3:0] nk_new;
    logic [3:0] nr_new;
    logic       len_ok;
    logic [5:0] total_new;

    always_comb begin
        nk_new = 4'd0;
        nr_new = 4'd0;
        len_ok = 1'b0;
        case (key_len_i)
            2'd0: begin nk_new = 4'd4; nr_new = 4'd10; len_ok = 1'b1; end
            2'd1: begin nk_new = 4'd6; nr_new = 4'd12; len_ok = (MAX_KEY_BITS >= 192); end
            2'd2: begin nk_new = 4'd8; nr_new = 4'd14; len_ok = (MAX_KEY_BITS >= 256); end
            default: ;
        endcase
    end

    assign total_new = {nr_new, 2'b00} + 6'd4;

    // ------------------------------------------------------------------
    // FSM next-state and control
    // ------------------------------------------------------------------
    logic accept;
    logic reject;
    logic gen_we;
    logic last_word;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        reject    = 1'b0;
        gen_we    = 1'b0;
        last_word = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    if (len_ok) begin
                        accept  = 1'b1;
                        state_d = ST_GEN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                gen_we = 1'b1;
                if (wcnt_q == total_q - 6'd1) begin
                    last_word = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Next-word computation: one shared 4-byte S-box lookup per cycle
    // ------------------------------------------------------------------
    logic [31:0] prev_w;
    logic [31:0] back_w;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp_w;
    logic [31:0] new_w;

    always_comb begin
        prev_w  = w_q[wcnt_q - 6'd1];
        back_w  = w_q[wcnt_q - {2'b00, nk_q}];
        sub_in  = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_out = sub_word(sub_in);
        if (j_q == 3'd0)
            temp_w = sub_out ^ {rcon_q, 24'h000000};
        else if (nk_q == 4'd8 && j_q == 3'd4)
            temp_w = sub_out;
        else
            temp_w = prev_w;
        new_w = back_w ^ temp_w;
    end

    // ------------------------------------------------------------------
    // Datapath registers and store
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) w_q[k] <= 32'h0;
            wcnt_q  <= 6'd0;
            j_q     <= 3'd0;
            rcon_q  <= 8'h01;
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            total_q <= 6'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= last_word;
            err_q  <= reject;
            if (accept) begin
                // Only the first Nk words are reloaded; older words above
                // them become unreachable because wcnt restarts at Nk.
                for (int k = 0; k < 8; k++) begin
                    if (4'(k) < nk_new) w_q[k] <= key_i[255 - 32*k -: 32];
                end
                wcnt_q  <= {2'b00, nk_new};
                j_q     <= 3'd0;
                rcon_q  <= 8'h01;
                nk_q    <= nk_new;
                nr_q    <= nr_new;
                total_q <= total_new;
            end else if (gen_we) begin
                if ({1'b0, wcnt_q} < DEPTH_W) w_q[wcnt_q] <= new_w;
                wcnt_q <= wcnt_q + 6'd1;
                j_q    <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0)
                    rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port (combinational); out-of-store addresses read as zero
    // ------------------------------------------------------------------
    logic [5:0] rd_addr;
    logic [6:0] need_words;

    always_comb begin
        rk_o    = '0;
        rd_addr = '0;
        for (int k = 0; k < 4; k++) begin
            rd_addr = {rk_idx_i, 2'b00} + 6'(k);
            if ({1'b0, rd_addr} < DEPTH_W) rk_o[127 - 32*k -: 32] = w_q[rd_addr];
        end
    end

    assign need_words = {1'b0, rk_idx_i, 2'b00} + 7'd4;
    assign rk_valid_o = (rk_idx_i <= nr_q) && ({1'b0, wcnt_q} >= need_words);

    assign busy_o      = (state_q == ST_GEN);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign nr_o        = nr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_key_schedule_multi.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule_multi
//
// Bench for aes_key_schedule_multi. It uses known-answer vectors from a
// table and random keys. The random keys are checked against a FIPS-style
// key-expansion model that uses a table S-box built by the log/antilog walk.
// It also runs directed sequences for rejection, ignored starts, mid-run
// reset, held start, and a second instance built with MAX_KEY_BITS=128.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule_multi;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT (full size) ----------------
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] rk;
    logic         rk_valid, busy, done, err;
    logic [3:0]   nr;
    logic [1:0]   dbg_state;

    aes_key_schedule_multi #(.MAX_KEY_BITS(256)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_len_i(key_len),
        .key_i(key), .rk_idx_i(rk_idx), .rk_o(rk), .rk_valid_o(rk_valid),
        .busy_o(busy), .done_o(done), .err_o(err), .nr_o(nr),
        .dbg_state_o(dbg_state)
    );

    // ---------------- DUT (AES-128 only) ----------------
    logic         s_start = 1'b0;
    logic [1:0]   s_len = 2'd0;
    logic [255:0] s_key = '0;
    logic [3:0]   s_idx = 4'd0;
    logic [127:0] s_rk;
    logic         s_valid, s_busy, s_done, s_err;
    logic [3:0]   s_nr;
    logic [1:0]   s_state;

    aes_key_schedule_multi #(.MAX_KEY_BITS(128)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .key_len_i(s_len),
        .key_i(s_key), .rk_idx_i(s_idx), .rk_o(s_rk), .rk_valid_o(s_valid),
        .busy_o(s_busy), .done_o(s_done), .err_o(s_err), .nr_o(s_nr),
        .dbg_state_o(s_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q[$];

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_t [256];
    logic [31:0] mw [60];
    logic [7:0]  rcon_tab [10];

    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        for (int it = 0; it < 255; it++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^
                        {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    function automatic logic [31:0] m_sub(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic model_expand(input logic [1:0] len, input logic [255:0] k);
        int nk, tw;
        logic [31:0] t;
        nk = 4 + 2 * int'(len);
        tw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < tw; i++) begin
            t = mw[i-1];
            if (i % nk == 0)
                t = m_sub({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = m_sub(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Starts one run and waits for done_o with a cycle budget.
    // Optionally pokes start_i during GEN at edge poke_at.
    task automatic run_key(input logic [1:0] len, input logic [255:0] k, input logic [3:0] probe,
                           input int poke_at, output int n_done, output int first_valid);
        bit seen_err;
        seen_err = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; key_len = len; key = k; rk_idx = probe;
        @(posedge clk); #1;                       // E0 has happened
        start = 1'b0;
        check_int("busy_after_start", busy, 1);
        check_int("nr_after_start", nr, 10 + 2 * int'(len));
        n_done = -1;
        first_valid = rk_valid ? 0 : -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == poke_at) begin
                start = 1'b1; key_len = 2'd2; key = {8{$urandom}};
            end
            if (n == poke_at + 2) start = 1'b0;
            @(posedge clk); #1;
            if (err) seen_err = 1'b1;
            if (rk_valid && first_valid < 0) first_valid = n;
            if (done) begin
                n_done = n;
                break;
            end
        end
        start = 1'b0;
        check_int("busy_at_done", busy, 0);
        check_int("err_during_run", int'(seen_err), 0);
        @(posedge clk); #1;
        check_int("done_one_cycle", done, 0);
    endtask

    task automatic check_rounds(input logic [1:0] len, input logic [255:0] k);
        int nrr;
        nrr = 10 + 2 * int'(len);
        model_expand(len, k);
        for (int r = 0; r <= nrr; r++)
            exp_q.push_back({mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
        for (int r = 0; r <= nrr; r++) begin
            rk_idx = 4'(r); #1;
            check_vec("round_key", rk, exp_q.pop_front());
            check_int("round_valid", rk_valid, 1);
        end
        if (nrr < 15) begin
            rk_idx = 4'(nrr + 1); #1;
            check_int("beyond_nr_valid", rk_valid, 0);
        end
    endtask

    function automatic int exp_first_valid(input logic [1:0] len, input logic [3:0] probe);
        int nk, v;
        nk = 4 + 2 * int'(len);
        if (int'(probe) > nk + 6) return -1;
        v = 4 * int'(probe) + 4 - nk;
        return (v < 0) ? 0 : v;
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]   len;
        logic [255:0] key;
        logic [3:0]   idx;
        logic [127:0] rk;
        int           cycles;
    } vec_t;

    vec_t vecs[4];

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
    localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // ---------------- test sequence ----------------
    initial begin
        int nd, fv, n1, n2;
        logic [1:0]   rl;
        logic [3:0]   rp;
        logic [255:0] rkey;

        build_sbox();
        vecs[0] = '{2'd0, KEY128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 40};
        vecs[1] = '{2'd0, KEY128, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 40};
        vecs[2] = '{2'd1, KEY192, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 46};
        vecs[3] = '{2'd2, KEY256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 52};

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_int("reset_busy", busy, 0);
        check_int("reset_done", done, 0);
        check_int("reset_err", err, 0);
        check_int("reset_nr", nr, 0);
        check_int("reset_valid0", rk_valid, 0);
        check_vec("reset_rk0", rk, '0);

        // reserved length from IDLE
        start = 1'b1; key_len = 2'd3; key = KEY256;
        @(posedge clk); #1;
        start = 1'b0;
        check_int("rsv_err_idle", err, 1);
        check_int("rsv_busy_idle", busy, 0);
        @(posedge clk); #1;
        check_int("rsv_err_pulse", err, 0);
        check_int("rsv_nr_idle", nr, 0);

        // known-answer table
        foreach (vecs[v]) begin
            run_key(vecs[v].len, vecs[v].key, vecs[v].idx, -1, nd, fv);
            check_int("kat_done_cycles", nd, vecs[v].cycles);
            check_int("kat_first_valid", fv, exp_first_valid(vecs[v].len, vecs[v].idx));
            rk_idx = vecs[v].idx; #1;
            check_vec("kat_round", rk, vecs[v].rk);
            check_rounds(vecs[v].len, vecs[v].key);
        end

        // reserved length from DONE: store untouched
        @(posedge clk); #1;
        start = 1'b1; key_len = 2'd3; key = KEY128;
        @(posedge clk); #1;
        start = 1'b0;
        check_int("rsv_err_done", err, 1);
        check_int("rsv_busy_done", busy, 0);
        check_int("rsv_nr_done", nr, 14);
        rk_idx = 4'd14; #1;
        check_vec("rsv_store_kept", rk, vecs[3].rk);
        check_int("rsv_valid_kept", rk_valid, 1);

        // progressive validity in AES-128
        run_key(2'd0, KEY128, 4'd3, -1, nd, fv);
        check_int("prog_idx3", fv, 12);
        run_key(2'd0, KEY128, 4'd11, -1, nd, fv);
        check_int("prog_idx11", fv, -1);

        // start during GEN ignored
        run_key(2'd0, KEY128, 4'd10, 10, nd, fv);
        check_int("poke_done_cycles", nd, 40);
        rk_idx = 4'd10; #1;
        check_vec("poke_round10", rk, vecs[1].rk);
        check_int("poke_nr", nr, 10);

        // random keys and lengths, restarts from DONE
        for (int it = 0; it < 6; it++) begin
            rl   = 2'($urandom_range(0, 2));
            rp   = 4'($urandom_range(0, 15));
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_key(rl, rkey, rp, (it % 2 == 1) ? 10 : -1, nd, fv);
            check_int("rand_done_cycles", nd, 4 * (10 + 2 * int'(rl) + 1) - (4 + 2 * int'(rl)));
            check_int("rand_first_valid", fv, exp_first_valid(rl, rp));
            check_rounds(rl, rkey);
        end

        // start held high: back-to-back runs
        @(posedge clk); #1;
        rkey = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        start = 1'b1; key_len = 2'd0; key = rkey;
        n1 = -1; n2 = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (done) begin
                if (n1 < 0) n1 = n;
                else begin
                    n2 = n;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check_int("held_start_interval", n2 - n1, 41);
        check_rounds(2'd0, rkey);

        // MAX_KEY_BITS=128 instance
        @(posedge clk); #1;
        s_start = 1'b1; s_len = 2'd2; s_key = KEY256;
        @(posedge clk); #1;
        s_start = 1'b0;
        check_int("small_err_256", s_err, 1);
        check_int("small_busy_256", s_busy, 0);
        s_start = 1'b1; s_len = 2'd1;
        @(posedge clk); #1;
        s_start = 1'b0;
        check_int("small_err_192", s_err, 1);
        check_int("small_busy_192", s_busy, 0);
        s_start = 1'b1; s_len = 2'd0; s_key = KEY128; s_idx = 4'd10;
        @(posedge clk); #1;
        s_start = 1'b0;
        check_int("small_busy_128", s_busy, 1);
        nd = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (s_done) begin
                nd = n;
                break;
            end
        end
        check_int("small_done_cycles", nd, 40);
        check_vec("small_round10", s_rk, vecs[1].rk);
        check_int("small_nr", s_nr, 10);

        // reset in the middle of an AES-256 run, at word 20
        @(posedge clk); #1;
        start = 1'b1; key_len = 2'd2; key = KEY256; rk_idx = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_int("midrun_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_int("async_busy", busy, 0);
        check_int("async_done", done, 0);
        check_int("async_err", err, 0);
        check_int("async_nr", nr, 0);
        check_int("async_valid0", rk_valid, 0);
        check_vec("async_rk0", rk, '0);
        check_int("async_state", dbg_state, 0);
        @(negedge clk); rst_n = 1'b1;
        run_key(2'd0, KEY128, 4'd10, -1, nd, fv);
        check_int("post_reset_cycles", nd, 40);
        rk_idx = 4'd1; #1;
        check_vec("post_reset_round1", rk, vecs[0].rk);
        rk_idx = 4'd10; #1;
        check_vec("post_reset_round10", rk, vecs[1].rk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
